// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates the byte-wide RAM/IO port between the instruction
// cache and the data cache. Each cache request is latched until it is served.
// It is split into 1, 2 or 4 little-endian byte cycles. Completion is signalled
// with a one-cycle pulse that carries the assembled read data.
module mem_ctrl #(
  parameter int         MEM_ADD_W = 32,
  parameter int         REG_DAT_W = 32,
  parameter logic [1:0] IO_ADD_HI = 2'b11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 iIC_En,
  input  logic [MEM_ADD_W-1:0] iIC_Add,
  output logic                 oIC_En,
  output logic [REG_DAT_W-1:0] oIC_Dat,
  input  logic                 iDC_En,
  input  logic                 iDC_Rw,
  input  logic [2:0]           iDC_Len,
  input  logic [MEM_ADD_W-1:0] iDC_Add,
  input  logic [REG_DAT_W-1:0] iDC_Dat,
  output logic                 oDC_En,
  output logic [REG_DAT_W-1:0] oDC_Dat,
  input  logic [7:0]           iMem_Din,
  output logic [7:0]           oMem_Dout,
  output logic [MEM_ADD_W-1:0] oMem_A,
  output logic                 oMem_Wr,
  input  logic                 iIO_Full
);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t                 r_state, w_state_nxt;

  // Latched requests; the pending flag stays set until the request completes
  logic                   r_ic_pend, w_ic_pend_nxt;
  logic [MEM_ADD_W-1:0]   r_ic_add;
  logic                   r_dc_pend, w_dc_pend_nxt;
  logic                   r_dc_rw;
  logic [2:0]             r_dc_len;
  logic [MEM_ADD_W-1:0]   r_dc_add;
  logic [REG_DAT_W-1:0]   r_dc_dat;

  // Active transaction
  logic                   r_sel_dc, w_sel_dc_nxt;
  logic [MEM_ADD_W-1:0]   r_base, w_base_nxt;
  logic [2:0]             r_len, w_len_nxt;
  logic [REG_DAT_W-1:0]   r_wdat, w_wdat_nxt;
  logic [REG_DAT_W-1:0]   r_rdat, w_rdat_nxt;
  logic [2:0]             r_iss, w_iss_nxt;
  logic [2:0]             r_cap, w_cap_nxt;
  logic                   r_vld_p0, w_vld_p0_nxt;
  logic                   r_vld_p1, w_vld_p1_nxt;

  // Registered outputs
  logic                   r_ic_en, w_ic_en_nxt;
  logic [REG_DAT_W-1:0]   r_ic_dat, w_ic_dat_nxt;
  logic                   r_dc_en, w_dc_en_nxt;
  logic [REG_DAT_W-1:0]   r_dc_dat_o, w_dc_dat_nxt;
  logic [7:0]             r_mem_dout, w_mem_dout_nxt;
  logic [MEM_ADD_W-1:0]   r_mem_a, w_mem_a_nxt;
  logic                   r_mem_wr, w_mem_wr_nxt;

  // Request as seen this cycle: the latched copy, or a pulse arriving now
  logic                   w_dc_req, w_dc_rw, w_ic_req;
  logic [2:0]             w_dc_len;
  logic [MEM_ADD_W-1:0]   w_dc_add, w_ic_add, w_iss_add;
  logic [REG_DAT_W-1:0]   w_dc_dat;
  logic [4:0]             w_iss_sh, w_cap_sh;

  assign w_dc_req  = r_dc_pend | iDC_En;
  assign w_dc_rw   = r_dc_pend ? r_dc_rw  : iDC_Rw;
  assign w_dc_len  = r_dc_pend ? r_dc_len : iDC_Len;
  assign w_dc_add  = r_dc_pend ? r_dc_add : iDC_Add;
  assign w_dc_dat  = r_dc_pend ? r_dc_dat : iDC_Dat;
  assign w_ic_req  = r_ic_pend | iIC_En;
  assign w_ic_add  = r_ic_pend ? r_ic_add : iIC_Add;
  assign w_iss_add = r_base + MEM_ADD_W'(r_iss);
  assign w_iss_sh  = {r_iss[1:0], 3'b000};
  assign w_cap_sh  = {r_cap[1:0], 3'b000};

  assign oIC_En    = r_ic_en;
  assign oIC_Dat   = r_ic_dat;
  assign oDC_En    = r_dc_en;
  assign oDC_Dat   = r_dc_dat_o;
  assign oMem_Dout = r_mem_dout;
  assign oMem_A    = r_mem_a;
  assign oMem_Wr   = r_mem_wr;

  // A write byte to IO space must wait while the IO buffer is full
  function automatic logic io_stall(input logic [MEM_ADD_W-1:0] addr,
                                    input logic                 full);
    return (addr[17:16] == IO_ADD_HI) && full;
  endfunction

  // Capture request fields on an accepted pulse; ignored while already pending
  always_ff @(posedge clk) begin
    if (iIC_En && !r_ic_pend) begin
      r_ic_add <= iIC_Add;
    end
    if (iDC_En && !r_dc_pend) begin
      r_dc_rw  <= iDC_Rw;
      r_dc_len <= iDC_Len;
      r_dc_add <= iDC_Add;
      r_dc_dat <= iDC_Dat;
    end
  end

  // Next-state, arbitration, byte sequencing and output values
  always_comb begin
    w_state_nxt    = r_state;
    w_ic_pend_nxt  = r_ic_pend | iIC_En;
    w_dc_pend_nxt  = r_dc_pend | iDC_En;
    w_sel_dc_nxt   = r_sel_dc;
    w_base_nxt     = r_base;
    w_len_nxt      = r_len;
    w_wdat_nxt     = r_wdat;
    w_rdat_nxt     = r_rdat;
    w_iss_nxt      = r_iss;
    w_cap_nxt      = r_cap;
    w_vld_p0_nxt   = r_vld_p0;
    w_vld_p1_nxt   = r_vld_p1;
    w_ic_en_nxt    = 1'b0;
    w_ic_dat_nxt   = r_ic_dat;
    w_dc_en_nxt    = 1'b0;
    w_dc_dat_nxt   = r_dc_dat_o;
    w_mem_dout_nxt = r_mem_dout;
    w_mem_a_nxt    = r_mem_a;
    w_mem_wr_nxt   = 1'b0;
    if (!en) begin
      // Paused: bytes in flight are lost, so a read restarts at the first uncaptured byte
      w_vld_p0_nxt = 1'b0;
      w_vld_p1_nxt = 1'b0;
      if (r_state == READ) w_iss_nxt = r_cap;
    end else begin
      unique case (r_state)
        IDLE: begin
          w_cap_nxt    = 3'd0;
          w_rdat_nxt   = '0;
          w_vld_p0_nxt = 1'b0;
          w_vld_p1_nxt = 1'b0;
          if (w_dc_req) begin
            w_sel_dc_nxt = 1'b1;
            w_base_nxt   = w_dc_add;
            w_len_nxt    = w_dc_len;
            w_wdat_nxt   = w_dc_dat;
            w_mem_a_nxt  = w_dc_add;
            if (w_dc_rw) begin
              w_state_nxt    = WRITE;
              w_mem_dout_nxt = w_dc_dat[7:0];
              if (io_stall(w_dc_add, iIO_Full)) begin
                w_iss_nxt = 3'd0;
              end else begin
                w_mem_wr_nxt = 1'b1;
                w_iss_nxt    = 3'd1;
              end
            end else begin
              w_state_nxt  = READ;
              w_vld_p0_nxt = 1'b1;
              w_iss_nxt    = 3'd1;
            end
          end else if (w_ic_req) begin
            w_sel_dc_nxt = 1'b0;
            w_base_nxt   = w_ic_add;
            w_len_nxt    = 3'd4;
            w_mem_a_nxt  = w_ic_add;
            w_state_nxt  = READ;
            w_vld_p0_nxt = 1'b1;
            w_iss_nxt    = 3'd1;
          end
        end
        READ: begin
          // p0: address on the bus; p1: its byte on iMem_Din
          w_vld_p1_nxt = r_vld_p0;
          if (r_iss < r_len) begin
            w_mem_a_nxt  = w_iss_add;
            w_iss_nxt    = r_iss + 3'd1;
            w_vld_p0_nxt = 1'b1;
          end else begin
            w_vld_p0_nxt = 1'b0;
          end
          if (r_vld_p1) begin
            w_rdat_nxt[w_cap_sh +: 8] = iMem_Din;
            w_cap_nxt = r_cap + 3'd1;
            if (r_cap + 3'd1 == r_len) begin
              w_state_nxt  = IDLE;
              w_vld_p0_nxt = 1'b0;
              w_vld_p1_nxt = 1'b0;
              if (r_sel_dc) begin
                w_dc_en_nxt   = 1'b1;
                w_dc_dat_nxt  = w_rdat_nxt;
                w_dc_pend_nxt = 1'b0;
              end else begin
                w_ic_en_nxt   = 1'b1;
                w_ic_dat_nxt  = w_rdat_nxt;
                w_ic_pend_nxt = 1'b0;
              end
            end
          end
        end
        WRITE: begin
          if (r_iss < r_len) begin
            w_mem_a_nxt    = w_iss_add;
            w_mem_dout_nxt = r_wdat[w_iss_sh +: 8];
            if (!io_stall(w_iss_add, iIO_Full)) begin
              w_mem_wr_nxt = 1'b1;
              w_iss_nxt    = r_iss + 3'd1;
            end
          end else begin
            w_state_nxt   = IDLE;
            w_dc_en_nxt   = 1'b1;
            w_dc_pend_nxt = 1'b0;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Control state and registered outputs, cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_ic_pend  <= 1'b0;
      r_dc_pend  <= 1'b0;
      r_sel_dc   <= 1'b0;
      r_iss      <= 3'd0;
      r_cap      <= 3'd0;
      r_vld_p0   <= 1'b0;
      r_vld_p1   <= 1'b0;
      r_ic_en    <= 1'b0;
      r_ic_dat   <= '0;
      r_dc_en    <= 1'b0;
      r_dc_dat_o <= '0;
      r_mem_dout <= 8'h00;
      r_mem_a    <= '0;
      r_mem_wr   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ic_pend  <= w_ic_pend_nxt;
      r_dc_pend  <= w_dc_pend_nxt;
      r_sel_dc   <= w_sel_dc_nxt;
      r_iss      <= w_iss_nxt;
      r_cap      <= w_cap_nxt;
      r_vld_p0   <= w_vld_p0_nxt;
      r_vld_p1   <= w_vld_p1_nxt;
      r_ic_en    <= w_ic_en_nxt;
      r_ic_dat   <= w_ic_dat_nxt;
      r_dc_en    <= w_dc_en_nxt;
      r_dc_dat_o <= w_dc_dat_nxt;
      r_mem_dout <= w_mem_dout_nxt;
      r_mem_a    <= w_mem_a_nxt;
      r_mem_wr   <= w_mem_wr_nxt;
    end
  end

  // Transaction data registers; only meaningful while a transaction is active
  always_ff @(posedge clk) begin
    r_base <= w_base_nxt;
    r_len  <= w_len_nxt;
    r_wdat <= w_wdat_nxt;
    r_rdat <= w_rdat_nxt;
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed testbench for mem_ctrl. The bench models a RAM with one cycle of
// read latency. Cycle 0 of each scenario is the cycle that carries the
// request pulse.
module tb_mem_ctrl;

  logic        clk, rst, en;
  logic        iIC_En;
  logic [31:0] iIC_Add;
  logic        oIC_En;
  logic [31:0] oIC_Dat;
  logic        iDC_En, iDC_Rw;
  logic [2:0]  iDC_Len;
  logic [31:0] iDC_Add, iDC_Dat;
  logic        oDC_En;
  logic [31:0] oDC_Dat;
  logic [7:0]  iMem_Din, oMem_Dout;
  logic [31:0] oMem_A;
  logic        oMem_Wr, iIO_Full;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_a = 32'h0;

  mem_ctrl dut (
    .clk(clk), .rst(rst), .en(en),
    .iIC_En(iIC_En), .iIC_Add(iIC_Add), .oIC_En(oIC_En), .oIC_Dat(oIC_Dat),
    .iDC_En(iDC_En), .iDC_Rw(iDC_Rw), .iDC_Len(iDC_Len), .iDC_Add(iDC_Add),
    .iDC_Dat(iDC_Dat), .oDC_En(oDC_En), .oDC_Dat(oDC_Dat),
    .iMem_Din(iMem_Din), .oMem_Dout(oMem_Dout), .oMem_A(oMem_A),
    .oMem_Wr(oMem_Wr), .iIO_Full(iIO_Full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM contents: 0x100..0x103 hold 11,22,33,44; elsewhere low address byte + 0x5A
  function automatic logic [7:0] ram_byte(input logic [31:0] a);
    case (a)
      32'h100: return 8'h11;
      32'h101: return 8'h22;
      32'h102: return 8'h33;
      32'h103: return 8'h44;
      default: return a[7:0] + 8'h5A;
    endcase
  endfunction

  // Advance to 1 time unit after the next rising edge and present RAM read data
  task automatic tick();
    @(posedge clk);
    #1;
    iMem_Din = ram_byte(last_a);
    last_a   = oMem_A;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({oIC_En, oIC_Dat, oDC_En, oDC_Dat, oMem_Dout, oMem_A, oMem_Wr} !== 108'h0) begin
      errors++;
      $display("FAIL reset_outputs got %h required 0",
               {oIC_En, oIC_Dat, oDC_En, oDC_Dat, oMem_Dout, oMem_A, oMem_Wr});
    end
    rst = 1'b0;
  endtask

  task automatic test_dc_read4();
    tick();
    iDC_En = 1'b1; iDC_Rw = 1'b0; iDC_Len = 3'd4; iDC_Add = 32'h100;
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c == 1) iDC_En = 1'b0;
      if (c <= 4) begin
        checks++;
        if (oMem_A !== 32'h100 + c - 1 || oMem_Wr !== 1'b0) begin
          errors++;
          $display("FAIL rd4_addr c=%0d got A=%h Wr=%b required A=%h Wr=0",
                   c, oMem_A, oMem_Wr, 32'h100 + c - 1);
        end
      end
      checks++;
      if (oDC_En !== (c == 6) || oIC_En !== 1'b0) begin
        errors++;
        $display("FAIL rd4_pulse c=%0d got DC=%b IC=%b required DC=%b IC=0",
                 c, oDC_En, oIC_En, (c == 6));
      end
      if (c == 6) begin
        checks++;
        if (oDC_Dat !== 32'h44332211) begin
          errors++;
          $display("FAIL rd4_data got %h required 44332211", oDC_Dat);
        end
      end
    end
  endtask

  task automatic test_dc_write2();
    tick();
    iDC_En = 1'b1; iDC_Rw = 1'b1; iDC_Len = 3'd2; iDC_Add = 32'h200;
    iDC_Dat = 32'hAABBCCDD;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 1) iDC_En = 1'b0;
      if (c == 1 || c == 2) begin
        checks++;
        if (oMem_A !== 32'h1FF + c || oMem_Wr !== 1'b1 ||
            oMem_Dout !== ((c == 1) ? 8'hDD : 8'hCC)) begin
          errors++;
          $display("FAIL wr2_byte c=%0d got A=%h D=%h Wr=%b required A=%h D=%h Wr=1",
                   c, oMem_A, oMem_Dout, oMem_Wr, 32'h1FF + c,
                   (c == 1) ? 8'hDD : 8'hCC);
        end
      end else begin
        checks++;
        if (oMem_Wr !== 1'b0) begin
          errors++;
          $display("FAIL wr2_idle_wr c=%0d got %b required 0", c, oMem_Wr);
        end
      end
      checks++;
      if (oDC_En !== (c == 3)) begin
        errors++;
        $display("FAIL wr2_pulse c=%0d got %b required %b", c, oDC_En, (c == 3));
      end
    end
    checks++;
    if (oDC_Dat !== 32'h44332211) begin
      errors++;
      $display("FAIL wr2_dat_hold got %h required 44332211", oDC_Dat);
    end
  endtask

  task automatic test_tie();
    tick();
    iDC_En = 1'b1; iDC_Rw = 1'b0; iDC_Len = 3'd1; iDC_Add = 32'h10;
    iIC_En = 1'b1; iIC_Add = 32'h0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 1) begin iDC_En = 1'b0; iIC_En = 1'b0; end
      if (c == 1 || c == 4) begin
        checks++;
        if (oMem_A !== ((c == 1) ? 32'h10 : 32'h0)) begin
          errors++;
          $display("FAIL tie_addr c=%0d got %h required %h", c, oMem_A,
                   (c == 1) ? 32'h10 : 32'h0);
        end
      end
      checks++;
      if (oDC_En !== (c == 3) || oIC_En !== (c == 9)) begin
        errors++;
        $display("FAIL tie_pulse c=%0d got DC=%b IC=%b required DC=%b IC=%b",
                 c, oDC_En, oIC_En, (c == 3), (c == 9));
      end
      if (c == 3) begin
        checks++;
        if (oDC_Dat !== 32'h0000006A) begin
          errors++;
          $display("FAIL tie_dc_data got %h required 0000006a", oDC_Dat);
        end
      end
      if (c == 9) begin
        checks++;
        if (oIC_Dat !== 32'h5D5C5B5A) begin
          errors++;
          $display("FAIL tie_ic_data got %h required 5d5c5b5a", oIC_Dat);
        end
      end
    end
  endtask

  task automatic test_io_stall();
    tick();
    iDC_En = 1'b1; iDC_Rw = 1'b1; iDC_Len = 3'd1; iDC_Add = 32'h30000;
    iDC_Dat = 32'h000000E7; iIO_Full = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 1) iDC_En = 1'b0;
      if (c == 3) iIO_Full = 1'b0;
      checks++;
      if (oMem_Wr !== (c == 4) || oDC_En !== (c == 5)) begin
        errors++;
        $display("FAIL io_stall c=%0d got Wr=%b DC=%b required Wr=%b DC=%b",
                 c, oMem_Wr, oDC_En, (c == 4), (c == 5));
      end
      if (c == 4) begin
        checks++;
        if (oMem_A !== 32'h30000 || oMem_Dout !== 8'hE7) begin
          errors++;
          $display("FAIL io_write got A=%h D=%h required A=00030000 D=e7",
                   oMem_A, oMem_Dout);
        end
      end
    end
  endtask

  task automatic test_en_pause();
    tick();
    iIC_En = 1'b1; iIC_Add = 32'h40;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 1) begin iIC_En = 1'b0; en = 1'b0; end
      if (c == 3) en = 1'b1;
      checks++;
      if (oMem_Wr !== 1'b0 || oIC_En !== (c == 9) || oDC_En !== 1'b0) begin
        errors++;
        $display("FAIL pause_ctrl c=%0d got Wr=%b IC=%b DC=%b required Wr=0 IC=%b DC=0",
                 c, oMem_Wr, oIC_En, oDC_En, (c == 9));
      end
      if (c == 4 || c == 7) begin
        checks++;
        if (oMem_A !== ((c == 4) ? 32'h40 : 32'h43)) begin
          errors++;
          $display("FAIL pause_addr c=%0d got %h required %h", c, oMem_A,
                   (c == 4) ? 32'h40 : 32'h43);
        end
      end
      if (c == 9) begin
        checks++;
        if (oIC_Dat !== 32'h9D9C9B9A) begin
          errors++;
          $display("FAIL pause_data got %h required 9d9c9b9a", oIC_Dat);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    tick();
    iDC_En = 1'b1; iDC_Rw = 1'b0; iDC_Len = 3'd4; iDC_Add = 32'h100;
    iIC_En = 1'b1; iIC_Add = 32'h80;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 1) begin iDC_En = 1'b0; iIC_En = 1'b0; end
      if (c == 2) rst = 1'b1;
      if (c == 3) begin
        rst = 1'b0;
        checks++;
        if ({oIC_En, oIC_Dat, oDC_En, oDC_Dat, oMem_Dout, oMem_A, oMem_Wr} !== 108'h0) begin
          errors++;
          $display("FAIL rstmid_outputs got %h required 0",
                   {oIC_En, oIC_Dat, oDC_En, oDC_Dat, oMem_Dout, oMem_A, oMem_Wr});
        end
      end
      if (c >= 4) begin
        checks++;
        if (oIC_En !== 1'b0 || oDC_En !== 1'b0 || oMem_A !== 32'h0 || oMem_Wr !== 1'b0) begin
          errors++;
          $display("FAIL rstmid_idle c=%0d got IC=%b DC=%b A=%h Wr=%b required 0,0,0,0",
                   c, oIC_En, oDC_En, oMem_A, oMem_Wr);
        end
      end
    end
  endtask

  task automatic test_read_len2();
    tick();
    iDC_En = 1'b1; iDC_Rw = 1'b0; iDC_Len = 3'd2; iDC_Add = 32'h102;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 1) iDC_En = 1'b0;
      checks++;
      if (oDC_En !== (c == 4)) begin
        errors++;
        $display("FAIL rd2_pulse c=%0d got %b required %b", c, oDC_En, (c == 4));
      end
      if (c == 2) begin
        checks++;
        if (oMem_A !== 32'h103) begin
          errors++;
          $display("FAIL rd2_addr got %h required 00000103", oMem_A);
        end
      end
      if (c == 4) begin
        checks++;
        if (oDC_Dat !== 32'h00004433) begin
          errors++;
          $display("FAIL rd2_data got %h required 00004433", oDC_Dat);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1;
    iIC_En = 1'b0; iIC_Add = 32'h0;
    iDC_En = 1'b0; iDC_Rw = 1'b0; iDC_Len = 3'd1; iDC_Add = 32'h0; iDC_Dat = 32'h0;
    iMem_Din = 8'h00; iIO_Full = 1'b0;
    test_reset();
    test_dc_read4();
    test_dc_write2();
    test_tie();
    test_io_stall();
    test_en_pause();
    test_reset_mid();
    test_read_len2();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Guard against a hung run
  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

endmodule
